// File: rtl/pma_region_table_if.sv
// Lookup/config bundle for pma_region_table: rule-write port plus request/response handshakes.
interface pma_region_table_if #(
  parameter int unsigned AddrWidth = 64
) ();
  logic                 cfg_we_i;
  logic [3:0]           cfg_idx_i;
  logic [AddrWidth-1:0] cfg_base_i;
  logic [AddrWidth-1:0] cfg_len_i;
  logic [2:0]           cfg_attr_i;
  logic                 cfg_lock_i;
  logic                 cfg_err_o;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic                 rsp_hit_o;
  logic [2:0]           rsp_attr_o;

  modport slave (
    input  cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_lock_i,
    output cfg_err_o,
    input  req_valid_i, req_addr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_attr_o
  );

  modport master (
    output cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_lock_i,
    input  cfg_err_o,
    output req_valid_i, req_addr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_attr_o
  );
endinterface

// File: rtl/pma_region_table.sv
// Physical-memory-attribute region table: priority base/length match with a one-deep response stage.
// Optional per-rule write lock is enabled by defining PMA_RULE_LOCK_EN.
module pma_region_table #(
  parameter int unsigned                          NrRules     = 4,
  parameter int unsigned                          AddrWidth   = 64,
  parameter logic [NrRules-1:0][AddrWidth-1:0]    RstBase     = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0]    RstLen      = '0,
  parameter logic [NrRules-1:0][2:0]              RstAttr     = '0,
  parameter logic [2:0]                           DefaultAttr = 3'b000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  pma_region_table_if.slave       bus
);

  logic [NrRules-1:0][AddrWidth-1:0] r_base;
  logic [NrRules-1:0][AddrWidth-1:0] r_len;
  logic [NrRules-1:0][2:0]           r_attr;

  logic [NrRules-1:0][AddrWidth:0]   w_end;
  logic [NrRules-1:0]                w_match;
  logic                              w_hit;
  logic [2:0]                        w_attr;
  logic                              w_idx_ok;
  logic                              w_locked;
  logic                              w_reject;
  logic [NrRules-1:0]                w_wr_sel;
  logic                              w_accept;

  logic                              r_rsp_valid;
  logic                              r_rsp_hit;
  logic [2:0]                        r_rsp_attr;
  logic                              r_cfg_err;

  // End address is one bit wider so a region reaching 2^AddrWidth does not wrap.
  always_comb begin
    w_end   = '0;
    w_match = '0;
    for (int i = 0; i < int'(NrRules); i++) begin
      w_end[i]   = {1'b0, r_base[i]} + {1'b0, r_len[i]};
      w_match[i] = (r_len[i] != '0) &&
                   ({1'b0, bus.req_addr_i} >= {1'b0, r_base[i]}) &&
                   ({1'b0, bus.req_addr_i} < w_end[i]);
    end
  end

  always_comb begin
    w_hit  = 1'b0;
    w_attr = DefaultAttr;
    for (int i = int'(NrRules) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit  = 1'b1;
        w_attr = r_attr[i];
      end else begin
        w_hit  = w_hit;
        w_attr = w_attr;
      end
    end
  end

`ifdef PMA_RULE_LOCK_EN
  logic [NrRules-1:0] r_lock;

  always_comb begin
    w_locked = 1'b0;
    for (int i = 0; i < int'(NrRules); i++) begin
      if (bus.cfg_idx_i == 4'(i)) begin
        w_locked = r_lock[i];
      end else begin
        w_locked = w_locked;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock <= '0;
    end else if (bus.cfg_lock_i) begin
      r_lock <= r_lock | w_wr_sel;
    end else begin
      r_lock <= r_lock;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = bus.cfg_lock_i;
  assign w_locked      = 1'b0;
`endif

  assign w_idx_ok = ({1'b0, bus.cfg_idx_i} < 5'(NrRules));
  assign w_reject = !w_idx_ok || w_locked;

  always_comb begin
    w_wr_sel = '0;
    for (int i = 0; i < int'(NrRules); i++) begin
      w_wr_sel[i] = bus.cfg_we_i && !w_reject && (bus.cfg_idx_i == 4'(i));
    end
  end

  // Reset reloads the parameterised rule set asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base <= RstBase;
      r_len  <= RstLen;
      r_attr <= RstAttr;
    end else begin
      for (int i = 0; i < int'(NrRules); i++) begin
        if (w_wr_sel[i]) begin
          r_base[i] <= bus.cfg_base_i;
          r_len[i]  <= bus.cfg_len_i;
          r_attr[i] <= bus.cfg_attr_i;
        end else begin
          r_base[i] <= r_base[i];
          r_len[i]  <= r_len[i];
          r_attr[i] <= r_attr[i];
        end
      end
    end
  end

  assign bus.req_ready_o = !r_rsp_valid || bus.rsp_ready_i;
  assign w_accept        = bus.req_valid_i && bus.req_ready_o;

  // Response is captured from pre-edge table contents and held until consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_attr  <= DefaultAttr;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= bus.cfg_we_i && w_reject;
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_hit   <= w_hit;
        r_rsp_attr  <= w_attr;
      end else if (bus.rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
        r_rsp_hit   <= r_rsp_hit;
        r_rsp_attr  <= r_rsp_attr;
      end else begin
        r_rsp_valid <= r_rsp_valid;
        r_rsp_hit   <= r_rsp_hit;
        r_rsp_attr  <= r_rsp_attr;
      end
    end
  end

  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_hit_o   = r_rsp_hit;
  assign bus.rsp_attr_o  = r_rsp_attr;
  assign bus.cfg_err_o   = r_cfg_err;

endmodule

// File: tb/tb_pma_region_table.sv
// Randomised and directed bench for pma_region_table against a rule-level reference model.
module tb_pma_region_table;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 64;
  localparam logic [NR-1:0][AW-1:0] RST_BASE = {64'hFFFF_FFFF_FFFF_F000, 64'h0, 64'h0, 64'h8000_0000};
  localparam logic [NR-1:0][AW-1:0] RST_LEN  = {64'h1000, 64'h0, 64'h0, 64'h4000_0000};
  localparam logic [NR-1:0][2:0]    RST_ATTR = {3'b011, 3'b000, 3'b000, 3'b101};
  localparam logic [2:0]            DEF      = 3'b010;
`ifdef PMA_RULE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pma_region_table_if #(.AddrWidth(AW)) bus ();

  pma_region_table #(
    .NrRules(NR), .AddrWidth(AW), .RstBase(RST_BASE), .RstLen(RST_LEN),
    .RstAttr(RST_ATTR), .DefaultAttr(DEF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rule table as plain arrays, response as a single expected slot.
  logic [63:0] m_base [NR];
  logic [63:0] m_len  [NR];
  logic [2:0]  m_attr [NR];
  bit          m_lock [NR];
  bit          e_valid, e_hit, e_err;
  logic [2:0]  e_attr;

  function automatic logic [3:0] ref_lookup(input logic [63:0] a);
    for (int i = 0; i < NR; i++) begin
      logic [64:0] top = {1'b0, m_base[i]} + {1'b0, m_len[i]};
      if (m_len[i] != 64'h0 && a >= m_base[i] && {1'b0, a} < top) return {1'b1, m_attr[i]};
    end
    return {1'b0, DEF};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        m_base[i] = RST_BASE[i];
        m_len[i]  = RST_LEN[i];
        m_attr[i] = RST_ATTR[i];
        m_lock[i] = 1'b0;
      end
      e_valid = 1'b0; e_hit = 1'b0; e_attr = DEF; e_err = 1'b0;
    end else begin
      logic [3:0] r;
      bit rdy;
      rdy = !e_valid || bus.rsp_ready_i;
      if (bus.req_valid_i && rdy) begin
        r = ref_lookup(bus.req_addr_i);
        e_valid = 1'b1; e_hit = r[3]; e_attr = r[2:0];
      end else if (bus.rsp_ready_i) begin
        e_valid = 1'b0;
      end
      e_err = 1'b0;
      if (bus.cfg_we_i) begin
        if (int'(bus.cfg_idx_i) >= NR || m_lock[bus.cfg_idx_i]) begin
          e_err = 1'b1;
        end else begin
          m_base[bus.cfg_idx_i] = bus.cfg_base_i;
          m_len[bus.cfg_idx_i]  = bus.cfg_len_i;
          m_attr[bus.cfg_idx_i] = bus.cfg_attr_i;
          if (LOCK && bus.cfg_lock_i) m_lock[bus.cfg_idx_i] = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rsp_valid", 64'(bus.rsp_valid_o), 64'(e_valid));
      check("req_ready", 64'(bus.req_ready_o), 64'(!e_valid || bus.rsp_ready_i));
      check("cfg_err", 64'(bus.cfg_err_o), 64'(e_err));
      if (e_valid) begin
        check("rsp_hit", 64'(bus.rsp_hit_o), 64'(e_hit));
        check("rsp_attr", 64'(bus.rsp_attr_o), 64'(e_attr));
      end
    end
  end

  task automatic idle();
    bus.cfg_we_i = 1'b0; bus.cfg_idx_i = 4'd0; bus.cfg_base_i = 64'h0; bus.cfg_len_i = 64'h0;
    bus.cfg_attr_i = 3'b000; bus.cfg_lock_i = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_addr_i = 64'h0; bus.rsp_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_ready", 64'(bus.req_ready_o), 64'd1);
    check("rst_hit", 64'(bus.rsp_hit_o), 64'd0);
    check("rst_attr", 64'(bus.rsp_attr_o), 64'(DEF));
    check("rst_err", 64'(bus.cfg_err_o), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic lookup_chk(input string name, input logic [63:0] a, input bit eh, input logic [2:0] ea);
    bus.req_valid_i = 1'b1; bus.req_addr_i = a; bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check({name, "_valid"}, 64'(bus.rsp_valid_o), 64'd1);
    check({name, "_hit"}, 64'(bus.rsp_hit_o), 64'(eh));
    check({name, "_attr"}, 64'(bus.rsp_attr_o), 64'(ea));
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic write_chk(input string name, input logic [3:0] idx, input logic [63:0] b,
                           input logic [63:0] l, input logic [2:0] at, input bit lk, input bit eerr);
    bus.cfg_we_i = 1'b1; bus.cfg_idx_i = idx; bus.cfg_base_i = b; bus.cfg_len_i = l;
    bus.cfg_attr_i = at; bus.cfg_lock_i = lk;
    @(negedge clk);
    check(name, 64'(bus.cfg_err_o), 64'(eerr));
    #1 bus.cfg_we_i = 1'b0; bus.cfg_lock_i = 1'b0;
  endtask

  initial begin
    do_reset();

    lookup_chk("rst_rule0", 64'h8000_0000, 1'b1, 3'b101);
    lookup_chk("rule0_last", 64'hBFFF_FFFF, 1'b1, 3'b101);
    lookup_chk("rule0_end", 64'hC000_0000, 1'b0, DEF);
    lookup_chk("top_addr", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b011);
    lookup_chk("below_top", 64'hFFFF_FFFF_FFFF_EFFF, 1'b0, DEF);

    write_chk("wr_r0", 4'd0, 64'h1000, 64'h1000, 3'b110, 1'b0, 1'b0);
    write_chk("wr_r1", 4'd1, 64'h0, 64'h10000, 3'b001, 1'b0, 1'b0);
    lookup_chk("prio_r0", 64'h1800, 1'b1, 3'b110);
    lookup_chk("prio_r1", 64'h2000, 1'b1, 3'b001);
    lookup_chk("miss", 64'h20000, 1'b0, DEF);

    // Same-cycle write and lookup: old rule answers, next lookup sees new one.
    bus.cfg_we_i = 1'b1; bus.cfg_idx_i = 4'd0; bus.cfg_base_i = 64'h1000;
    bus.cfg_len_i = 64'h1000; bus.cfg_attr_i = 3'b111;
    lookup_chk("same_cyc_old", 64'h1800, 1'b1, 3'b110);
    bus.cfg_we_i = 1'b0;
    lookup_chk("next_new", 64'h1800, 1'b1, 3'b111);

    bus.rsp_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h1800;
    @(negedge clk);
    #1 bus.req_addr_i = 64'h2000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", 64'(bus.req_ready_o), 64'd0);
      check("stall_attr", 64'(bus.rsp_attr_o), 64'(3'b111));
    end
    #1 bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("b2b_1", 64'(bus.rsp_attr_o), 64'(3'b001));
    #1 bus.req_addr_i = 64'h20000;
    @(negedge clk);
    check("b2b_2_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("b2b_2_hit", 64'(bus.rsp_hit_o), 64'd0);
    #1 bus.req_valid_i = 1'b0;

    write_chk("lock_wr", 4'd2, 64'h40000, 64'h100, 3'b100, 1'b1, 1'b0);
    write_chk("locked_rewr", 4'd2, 64'h50000, 64'h100, 3'b110, 1'b0, LOCK);
    lookup_chk("locked_keep", 64'h40080, LOCK, LOCK ? 3'b100 : DEF);
    write_chk("idx_oob", 4'd4, 64'h0, 64'h10, 3'b111, 1'b0, 1'b1);

    // Reset with a stalled response pending.
    bus.rsp_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h1800;
    @(negedge clk);
    #1;
    do_reset();
    lookup_chk("post_rst", 64'h8000_0000, 1'b1, 3'b101);
    lookup_chk("post_rst_r0", 64'h1800, 1'b0, DEF);
    write_chk("unlock_wr", 4'd2, 64'h50000, 64'h100, 3'b110, 1'b0, 1'b0);
    lookup_chk("unlock_lu", 64'h50010, 1'b1, 3'b110);

    for (int n = 0; n < 600; n++) begin
      bus.cfg_we_i    = ($urandom_range(0, 4) == 0);
      bus.cfg_idx_i   = 4'($urandom_range(0, 5));
      bus.cfg_base_i  = 64'($urandom_range(0, 31)) << 12;
      bus.cfg_len_i   = 64'($urandom_range(0, 3)) << 13;
      bus.cfg_attr_i  = 3'($urandom_range(0, 7));
      bus.cfg_lock_i  = ($urandom_range(0, 7) == 0);
      bus.req_valid_i = ($urandom_range(0, 1) == 1);
      bus.req_addr_i  = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 8191))
                                                      : 64'($urandom_range(0, 32'h24000));
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      #1;
    end
    idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
